regfile_arbiter: RTL and testbench
==================================

# regfile_arbiter

Two-port arbiter and access sequencer for the single-port 8 x 8-bit `register_file`. It lets two requesters share the file's one address/write/in/out port, for example the instruction decode operand read and the writeback stage. It grants one requester at a time using round-robin, drives the file's port for the required number of cycles, captures read data, and returns a one-cycle acknowledge. It sits between the core datapath requesters and the `register_file` instance.

## Interface
Parameters:
- `ADDR_W`, 3, register address width (8 registers)
- `DATA_W`, 8, register data width
- `RD_LAT`, 1, clock cycles from `rf_address` applied to valid `rf_out`; legal values are 0..3

Ports:
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `req0`  in  1  port 0 request; must be held until `ack0`
- `we0`  in  1  port 0 operation: 1 = write, 0 = read
- `addr0`  in  ADDR_W  port 0 register address
- `wdata0`  in  DATA_W  port 0 write data
- `ack0`  out  1  port 0 one-cycle completion pulse
- `rdata0`  out  DATA_W  port 0 read data; valid with `ack0` and held until the next port 0 read completes
- `req1`, `we1`, `addr1`, `wdata1`, `ack1`, `rdata1`: same as port 0, for port 1
- `rf_address`  out  ADDR_W  drives `register_file.address`
- `rf_write`  out  1  drives `register_file.write`
- `rf_in`  out  DATA_W  drives `register_file.in`
- `rf_out`  in  DATA_W  driven by `register_file.out`

## Operation
- FSM states:
  - IDLE: no access is in progress.
  - ACCESS: the arbiter drives the file port.
  - DONE: the arbiter pulses the acknowledge.
- Transitions:
  - IDLE to ACCESS when any request is pending.
  - ACCESS to DONE after 1 cycle for a write, or after RD_LAT+1 cycles for a read. A 2-bit down-counter tracks the read cycles.
  - DONE to IDLE, always.
- Arbitration happens only in IDLE:
  - If one request is pending, that requester wins.
  - If both are pending, the port that was not granted last wins.
  - `last_gnt` updates on entry to ACCESS.
- Request fields are latched on entry to ACCESS: winner, `we`, `addr`, `wdata`. Changes on the inputs after that point are ignored.
- File port drive:
  - In ACCESS, `rf_address` is the latched address.
  - In ACCESS, `rf_write` is 1 for a write and `rf_in` is the latched data.
  - In all other states, `rf_write` is 0, and `rf_address` and `rf_in` are 0.
- A read samples `rf_out` into the winner's `rdata` register at the clock edge that ends the final ACCESS cycle.
- `ackN` is high for exactly the DONE cycle, and only for the granted port.
- A request is consumed by its ack. A requester holding `req` high after its ack is arbitrated again as a new request in the following IDLE.
- Deasserting `req` before its ack is a protocol violation. The latched transaction completes anyway, including the write, and the ack still pulses.
- If both ports target the same address, the accesses are serialized in grant order, so a read granted after a write returns the new value.
- Reset values:
  - State: IDLE.
  - `ack0`, `ack1`: 0.
  - `rdata0`, `rdata1`: 0.
  - `rf_write`, `rf_address`, `rf_in`: 0.
  - `last_gnt`: 1, so port 0 wins the first tie.
- Reset asserted mid-access aborts the transaction immediately:
  - `rf_write` drops asynchronously.
  - No ack is issued.
  - A write already clocked into the file is not undone.

## Timing
- Cycle 0 is the IDLE cycle in which `req` is sampled high.
- Write: ACCESS in cycle 1, with the file written at the end of cycle 1. `ack` in cycle 2. Request-to-ack latency is 2 cycles.
- Read: ACCESS in cycles 1..RD_LAT+1. `ack` and valid `rdata` in cycle RD_LAT+2. With the default RD_LAT=1, latency is 3 cycles.
- Throughput:
  - Back-to-back writes: one every 3 cycles (IDLE, ACCESS, DONE).
  - Back-to-back reads: one every RD_LAT+3 cycles.
- With both ports continuously requesting, grants alternate 0,1,0,1.

## Configuration
- `REGFILE_ARB_FIXED_PRIO_EN`:
  - When defined, port 0 always wins a simultaneous request and `last_gnt` is not used.
  - When undefined (the default), arbitration is round-robin as specified above.

## Test plan
- Reset, then port 0 writes 8'h01 to r0 -> `rf_write`=1 only in cycle 1, `ack0` in cycle 2. A port 0 read of r0 then gives `ack0` 3 cycles after request, with `rdata0`=8'h01.
- Port 1 writes 8'hAB to r7, then reads r7 -> `rdata1`=8'hAB. `rdata0` stays unchanged and `ack0` stays 0.
- `req0` and `req1` both held high for 4 transactions -> grant order 0,1,0,1. With `REGFILE_ARB_FIXED_PRIO_EN` defined, the order is 0,0,0,0 while `req0` stays high.
- Same cycle: port 0 writes 8'h5A to r3 and port 1 reads r3 -> `ack0` first, then `ack1` with `rdata1`=8'h5A.
- Assert `reset` in the ACCESS cycle of a port 1 read -> all outputs are 0 within the same cycle, `ack1` never pulses, and the next tie grants port 0.
- Rerun a read with RD_LAT=0 and RD_LAT=3 (and a matching file model) -> ack latency of 2 and 5 cycles respectively, with correct data.

Source files
------------

// File: rtl/regfile_arbiter.sv
// Round-robin two-port arbiter and access sequencer for a single-port register file.
// Define REGFILE_ARB_FIXED_PRIO_EN to give port 0 fixed priority instead.
module regfile_arbiter #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] rf_address,
    output logic              rf_write,
    output logic [DATA_W-1:0] rf_in,
    input  logic [DATA_W-1:0] rf_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_t;

    localparam logic [1:0] RD_CNT = 2'(RD_LAT);

    state_t            r_state;
    state_t            w_next;
    logic              r_gnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata0;
    logic [DATA_W-1:0] r_rdata1;
    logic [1:0]        r_cnt;
    logic              w_win;
    logic              w_start;
    logic              w_last;
    logic              w_sel_we;

    assign w_start  = (r_state == S_IDLE) && (req0 || req1);
    assign w_last   = (r_state == S_ACCESS) && (r_cnt == 2'd0);
    assign w_sel_we = w_win ? we1 : we0;
    assign rdata0   = r_rdata0;
    assign rdata1   = r_rdata1;

`ifdef REGFILE_ARB_FIXED_PRIO_EN
    assign w_win = ~req0;
`else
    logic r_last_gnt;

    // On a tie the port not granted last wins; a lone request wins outright.
    assign w_win = (req0 && req1) ? ~r_last_gnt : ~req0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_gnt <= 1'b1;
        end else if (w_start) begin
            r_last_gnt <= w_win;
        end
    end
`endif

    always_comb begin
        w_next     = r_state;
        ack0       = 1'b0;
        ack1       = 1'b0;
        rf_address = '0;
        rf_write   = 1'b0;
        rf_in      = '0;
        unique case (r_state)
            S_IDLE: begin
                if (req0 || req1) w_next = S_ACCESS;
            end
            S_ACCESS: begin
                rf_address = r_addr;
                rf_write   = r_we;
                rf_in      = r_wdata;
                if (r_cnt == 2'd0) w_next = S_DONE;
            end
            S_DONE: begin
                ack0   = ~r_gnt;
                ack1   = r_gnt;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_gnt    <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_cnt    <= 2'd0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_gnt   <= w_win;
                r_we    <= w_sel_we;
                r_addr  <= w_win ? addr1 : addr0;
                r_wdata <= w_win ? wdata1 : wdata0;
                // Writes take one ACCESS cycle, reads RD_LAT+1.
                r_cnt   <= w_sel_we ? 2'd0 : RD_CNT;
            end else if (r_state == S_ACCESS && r_cnt != 2'd0) begin
                r_cnt <= r_cnt - 2'd1;
            end
            if (w_last && !r_we) begin
                if (r_gnt) r_rdata1 <= rf_out;
                else       r_rdata0 <= rf_out;
            end
        end
    end

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: three lanes with RD_LAT 1, 0 and 3,
// each with its own register file model.
module tb_regfile_arbiter;

    logic       clock;
    logic       reset;
    logic       req0   [3];
    logic       we0    [3];
    logic [2:0] addr0  [3];
    logic [7:0] wdata0 [3];
    logic       ack0   [3];
    logic [7:0] rdata0 [3];
    logic       req1   [3];
    logic       we1    [3];
    logic [2:0] addr1  [3];
    logic [7:0] wdata1 [3];
    logic       ack1   [3];
    logic [7:0] rdata1 [3];
    logic [2:0] rf_address [3];
    logic       rf_write   [3];
    logic [7:0] rf_in      [3];
    logic [7:0] rf_out     [3];

    int n_tests = 0;
    int n_fail  = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_lane
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        logic [7:0] mem [8];
        logic [7:0] rd0;
        logic [7:0] p1;
        logic [7:0] p2;
        logic [7:0] p3;

        regfile_arbiter #(
            .ADDR_W(3),
            .DATA_W(8),
            .RD_LAT(LAT)
        ) u_dut (
            .clock      (clock),
            .reset      (reset),
            .req0       (req0[g]),
            .we0        (we0[g]),
            .addr0      (addr0[g]),
            .wdata0     (wdata0[g]),
            .ack0       (ack0[g]),
            .rdata0     (rdata0[g]),
            .req1       (req1[g]),
            .we1        (we1[g]),
            .addr1      (addr1[g]),
            .wdata1     (wdata1[g]),
            .ack1       (ack1[g]),
            .rdata1     (rdata1[g]),
            .rf_address (rf_address[g]),
            .rf_write   (rf_write[g]),
            .rf_in      (rf_in[g]),
            .rf_out     (rf_out[g])
        );

        always_ff @(posedge clock) begin
            if (rf_write[g]) mem[rf_address[g]] <= rf_in[g];
        end

        assign rd0 = mem[rf_address[g]];

        always_ff @(posedge clock) begin
            p1 <= rd0;
            p2 <= p1;
            p3 <= p2;
        end

        assign rf_out[g] = (LAT == 0) ? rd0 : (LAT == 1) ? p1 : (LAT == 2) ? p2 : p3;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic access(input int l, input bit p, input bit w,
                          input logic [2:0] a, input logic [7:0] d,
                          output int lat, output bit other);
        bit done;
        done  = 1'b0;
        other = 1'b0;
        lat   = 0;
        if (!p) begin
            we0[l] = w; addr0[l] = a; wdata0[l] = d; req0[l] = 1'b1;
        end else begin
            we1[l] = w; addr1[l] = a; wdata1[l] = d; req1[l] = 1'b1;
        end
        while (!done && lat < 20) begin
            tick();
            lat++;
            if (p ? ack0[l] : ack1[l]) other = 1'b1;
            if (p ? ack1[l] : ack0[l]) done = 1'b1;
        end
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL access_timeout lane %0d port %0d: no ack in %0d cycles", l, p, lat);
        end
        req0[l] = 1'b0;
        req1[l] = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        for (int l = 0; l < 3; l++) begin
            req0[l] = 0; we0[l] = 0; addr0[l] = 0; wdata0[l] = 0;
            req1[l] = 0; we1[l] = 0; addr1[l] = 0; wdata1[l] = 0;
        end
        reset = 1'b1;
        tick();
        tick();
        for (int l = 0; l < 3; l++) begin
            n_tests++;
            if ({ack0[l], ack1[l], rf_write[l], rf_address[l], rf_in[l], rdata0[l], rdata1[l]} !== 30'd0) begin
                n_fail++;
                $display("FAIL reset_outputs lane %0d: got %h%h%h%h%h%h%h required all 0", l,
                         ack0[l], ack1[l], rf_write[l], rf_address[l], rf_in[l], rdata0[l], rdata1[l]);
            end
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write_read();
        int  lat;
        bit  oth;
        we0[0] = 1'b1; addr0[0] = 3'd0; wdata0[0] = 8'h01; req0[0] = 1'b1;
        tick();
        n_tests++;
        if ({rf_write[0], rf_address[0], rf_in[0], ack0[0]} !== {1'b1, 3'd0, 8'h01, 1'b0}) begin
            n_fail++;
            $display("FAIL write_cycle1: got we=%b a=%0d d=%h ack=%b required 1 0 01 0",
                     rf_write[0], rf_address[0], rf_in[0], ack0[0]);
        end
        tick();
        n_tests++;
        if ({ack0[0], ack1[0], rf_write[0]} !== 3'b100) begin
            n_fail++;
            $display("FAIL write_cycle2: got ack0=%b ack1=%b we=%b required 1 0 0",
                     ack0[0], ack1[0], rf_write[0]);
        end
        req0[0] = 1'b0;
        tick();
        n_tests++;
        if (ack0[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL ack_pulse_width: got ack0=%b required 0", ack0[0]);
        end
        access(0, 1'b0, 1'b0, 3'd0, 8'h00, lat, oth);
        n_tests++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL read_latency: got %0d required 3", lat);
        end
        n_tests++;
        if (rdata0[0] !== 8'h01) begin
            n_fail++;
            $display("FAIL read_r0: got %h required 01", rdata0[0]);
        end
    endtask

    task automatic test_port1();
        int lat;
        bit oth;
        bit oth_any;
        access(0, 1'b1, 1'b1, 3'd7, 8'hAB, lat, oth);
        oth_any = oth;
        n_tests++;
        if (lat !== 2) begin
            n_fail++;
            $display("FAIL p1_write_latency: got %0d required 2", lat);
        end
        access(0, 1'b1, 1'b0, 3'd7, 8'h00, lat, oth);
        oth_any = oth_any | oth;
        n_tests++;
        if (lat !== 3) begin
            n_fail++;
            $display("FAIL p1_read_latency: got %0d required 3", lat);
        end
        n_tests++;
        if (rdata1[0] !== 8'hAB) begin
            n_fail++;
            $display("FAIL p1_read_r7: got %h required ab", rdata1[0]);
        end
        n_tests++;
        if (rdata0[0] !== 8'h01 || oth_any !== 1'b0) begin
            n_fail++;
            $display("FAIL p1_isolation: got rdata0=%h ack0_seen=%b required 01 0", rdata0[0], oth_any);
        end
    endtask

    task automatic test_round_robin();
        int got   [4];
        int at    [4];
        int exp_p [4];
        int k;
        int cyc;
        int bad;
`ifdef REGFILE_ARB_FIXED_PRIO_EN
        exp_p = '{0, 0, 0, 0};
`else
        exp_p = '{0, 1, 0, 1};
`endif
        k = 0; cyc = 0; bad = 0;
        we0[0] = 1'b1; addr0[0] = 3'd1; wdata0[0] = 8'h10;
        we1[0] = 1'b1; addr1[0] = 3'd2; wdata1[0] = 8'h20;
        req0[0] = 1'b1; req1[0] = 1'b1;
        while (k < 4 && cyc < 60) begin
            tick();
            cyc++;
            if (ack0[0] && ack1[0]) bad++;
            else if (ack0[0]) begin got[k] = 0; at[k] = cyc; k++; end
            else if (ack1[0]) begin got[k] = 1; at[k] = cyc; k++; end
        end
        req0[0] = 1'b0;
        req1[0] = 1'b0;
        tick();
        n_tests++;
        if (k !== 4 || bad !== 0) begin
            n_fail++;
            $display("FAIL rr_count: got %0d acks, %0d double acks, required 4 and 0", k, bad);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < k) begin
                n_tests++;
                if (got[i] !== exp_p[i] || at[i] !== 2 + 3 * i) begin
                    n_fail++;
                    $display("FAIL rr_grant %0d: got port %0d at cycle %0d required port %0d at cycle %0d",
                             i, got[i], at[i], exp_p[i], 2 + 3 * i);
                end
            end
        end
    endtask

    task automatic test_same_addr();
        int first;
        int c1;
        int cyc;
        first = -1; c1 = -1; cyc = 0;
        we0[0] = 1'b1; addr0[0] = 3'd3; wdata0[0] = 8'h5A;
        we1[0] = 1'b0; addr1[0] = 3'd3; wdata1[0] = 8'h00;
        req0[0] = 1'b1; req1[0] = 1'b1;
        while (c1 < 0 && cyc < 30) begin
            tick();
            cyc++;
            if (ack0[0]) begin
                if (first < 0) first = 0;
                req0[0] = 1'b0;
            end
            if (ack1[0]) begin
                if (first < 0) first = 1;
                c1 = cyc;
                req1[0] = 1'b0;
            end
        end
        req0[0] = 1'b0;
        req1[0] = 1'b0;
        tick();
        n_tests++;
        if (first !== 0 || c1 !== 6) begin
            n_fail++;
            $display("FAIL same_addr_order: got first=%0d ack1_cycle=%0d required 0 6", first, c1);
        end
        n_tests++;
        if (rdata1[0] !== 8'h5A) begin
            n_fail++;
            $display("FAIL same_addr_data: got %h required 5a", rdata1[0]);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        int first;
        int cyc;
        seen = 0; first = -1; cyc = 0;
        we1[0] = 1'b0; addr1[0] = 3'd7; req1[0] = 1'b1;
        tick();
        n_tests++;
        if (rf_address[0] !== 3'd7) begin
            n_fail++;
            $display("FAIL mid_access_addr: got %0d required 7", rf_address[0]);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if ({ack0[0], ack1[0], rf_write[0], rf_address[0], rf_in[0], rdata0[0], rdata1[0]} !== 30'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %h %h %h %h %h %h %h required all 0",
                     ack0[0], ack1[0], rf_write[0], rf_address[0], rf_in[0], rdata0[0], rdata1[0]);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            if (ack1[0]) seen++;
        end
        req1[0] = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ack1[0]) seen++;
        end
        n_tests++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL mid_reset_no_ack: got %0d ack1 pulses required 0", seen);
        end
        we0[0] = 1'b1; addr0[0] = 3'd4; wdata0[0] = 8'h77; req0[0] = 1'b1;
        tick();
        n_tests++;
        if (rf_write[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_write_pre: got rf_write=%b required 1", rf_write[0]);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (rf_write[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_write_async: got rf_write=%b required 0", rf_write[0]);
        end
        req0[0] = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        we0[0] = 1'b1; addr0[0] = 3'd5; wdata0[0] = 8'h11; req0[0] = 1'b1;
        we1[0] = 1'b1; addr1[0] = 3'd6; wdata1[0] = 8'h22; req1[0] = 1'b1;
        while (first < 0 && cyc < 20) begin
            tick();
            cyc++;
            if (ack0[0]) first = 0;
            else if (ack1[0]) first = 1;
        end
        req0[0] = 1'b0;
        req1[0] = 1'b0;
        tick();
        tick();
        n_tests++;
        if (first !== 0) begin
            n_fail++;
            $display("FAIL post_reset_tie: got port %0d required 0", first);
        end
    endtask

    task automatic test_latency();
        int lat;
        bit oth;
        int exp_l [3];
        exp_l = '{3, 2, 5};
        for (int l = 1; l < 3; l++) begin
            access(l, 1'b0, 1'b1, 3'd5, 8'h3C, lat, oth);
            n_tests++;
            if (lat !== 2) begin
                n_fail++;
                $display("FAIL lat_write lane %0d: got %0d required 2", l, lat);
            end
            access(l, 1'b0, 1'b0, 3'd5, 8'h00, lat, oth);
            n_tests++;
            if (lat !== exp_l[l] || rdata0[l] !== 8'h3C) begin
                n_fail++;
                $display("FAIL lat_read lane %0d: got lat=%0d data=%h required %0d 3c",
                         l, lat, rdata0[l], exp_l[l]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_port1();
        test_round_robin();
        test_same_addr();
        test_reset_mid();
        test_latency();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
